// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: latches PC, issues a word read, waits for MFC with a
// timeout, then strobes IR_In/IR_Enable for one cycle. Supports flush and faults.
module instr_fetch_unit #(
  parameter logic [5:0]  READ_WORD_OP = 6'b000000,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic [31:0] PC,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic        fault_ack,
  output logic [31:0] RAM_Address,
  output logic        RAM_enable,
  output logic [5:0]  RAM_OpCode,
  input  logic [31:0] RAM_DataOut,
  input  logic        MFC,
  output logic [31:0] IR_In,
  output logic        IR_Enable,
  output logic        fetch_done,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_FAULT
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_MISALIGN  = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT   = 2'b10;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [7:0]  count_reg;
  logic [7:0]  count_inc;

  // Saturating increment so a large TIMEOUT can never wrap the counter.
  assign count_inc = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;

  assign RAM_Address = addr_reg;
  assign RAM_OpCode  = READ_WORD_OP;
  assign busy        = (state_reg == S_REQ) || (state_reg == S_WAIT) || (state_reg == S_LOAD);
  assign fault       = (state_reg == S_FAULT);

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_reg  <= S_IDLE;
      addr_reg   <= 32'd0;
      count_reg  <= 8'd0;
      RAM_enable <= 1'b0;
      IR_In      <= 32'd0;
      IR_Enable  <= 1'b0;
      fetch_done <= 1'b0;
      fault_code <= CODE_NONE;
    end else begin
      IR_Enable  <= 1'b0;
      fetch_done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (fetch_req) begin
            if (PC[1:0] != 2'b00) begin
              fault_code <= CODE_MISALIGN;
              state_reg  <= S_FAULT;
            end else begin
              addr_reg   <= PC;
              count_reg  <= 8'd0;
              RAM_enable <= 1'b1;
              state_reg  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (flush) begin
            RAM_enable <= 1'b0;
            state_reg  <= S_IDLE;
          end else begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Flush takes priority over a same-cycle MFC: the word is discarded.
          if (flush) begin
            RAM_enable <= 1'b0;
            state_reg  <= S_IDLE;
          end else if (MFC) begin
            IR_In      <= RAM_DataOut;
            IR_Enable  <= 1'b1;
            fetch_done <= 1'b1;
            RAM_enable <= 1'b0;
            state_reg  <= S_LOAD;
          end else begin
            count_reg <= count_inc;
            if (count_inc >= TIMEOUT_CNT) begin
              fault_code <= CODE_TIMEOUT;
              RAM_enable <= 1'b0;
              state_reg  <= S_FAULT;
            end
          end
        end
        S_LOAD: begin
          state_reg <= S_IDLE;
        end
        S_FAULT: begin
          if (fault_ack) begin
            fault_code <= CODE_NONE;
            state_reg  <= S_IDLE;
          end
        end
        default: begin
          RAM_enable <= 1'b0;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage placed directly upstream of the DataPath IR. On a fetch request from ControlUnit, it:
- latches the PC,
- issues a word read to RAM,
- waits for MFC, with a timeout,
- drives IR_In/IR_Enable for exactly one cycle.

It also supports flush/abort for branches and traps, and reports misaligned-PC and memory-timeout faults to ControlUnit.

## Interface
Parameters:
- READ_WORD_OP, 6'b000000, RAM_OpCode value for a 32-bit word read
- TIMEOUT, 15, maximum cycles spent in WAIT without MFC before a timeout fault (range 1..255)

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- PC  in  32  current program counter from DataPath
- fetch_req  in  1  start a fetch; sampled only in IDLE
- flush  in  1  abort any in-flight fetch (branch/trap redirect)
- fault_ack  in  1  clears FAULT state
- RAM_Address  out  32  word address presented to RAM
- RAM_enable  out  1  RAM access strobe
- RAM_OpCode  out  6  RAM operation code
- RAM_DataOut  in  32  RAM read data, valid when MFC=1
- MFC  in  1  memory function complete
- IR_In  out  32  fetched instruction word, registered
- IR_Enable  out  1  one-cycle IR load strobe
- fetch_done  out  1  one-cycle pulse coincident with IR_Enable
- busy  out  1  high in REQ, WAIT, LOAD
- fault  out  1  high while in FAULT
- fault_code  out  2  01 = misaligned PC, 10 = memory timeout, 00 = none

## Operation
States: IDLE, REQ, WAIT, LOAD, FAULT.

- **IDLE**
  - On fetch_req=1 with PC[1:0]!=0: latch fault_code=01 and go to FAULT.
  - On fetch_req=1 with PC[1:0]==0: latch PC into addr_q, clear the timeout counter, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - Outputs: RAM_enable=1, RAM_Address=addr_q, RAM_OpCode=READ_WORD_OP.
  - Next state: WAIT.
- **WAIT**
  - RAM_enable and RAM_Address stay held.
  - On MFC=1: capture RAM_DataOut into IR_In and go to LOAD.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set fault_code=10, drop RAM_enable, and go to FAULT.
- **LOAD**
  - Outputs: IR_Enable=1, fetch_done=1, RAM_enable=0.
  - Next state: IDLE.
- **FAULT**
  - fault=1. RAM_enable, IR_Enable and fetch_done are all 0.
  - On fault_ack=1, go to IDLE and clear fault_code to 00.
- **flush**
  - In REQ or WAIT: return to IDLE next cycle. IR_Enable is not asserted and IR_In is unchanged.
  - If flush=1 and MFC=1 arrive in the same cycle, flush wins.
  - In IDLE, LOAD or FAULT: flush has no effect.
- **fetch_req outside IDLE:** ignored; no queuing.
- **Counter:** 8-bit, saturating; compared with TIMEOUT using an unsigned compare.
- **IR_In:** holds its last fetched value until the next successful capture.

## Timing
- **Reset values:** RESET=1 at a rising edge forces state=IDLE, with:
  - IR_In=0, IR_Enable=0, fetch_done=0
  - RAM_enable=0, RAM_Address=0, RAM_OpCode=READ_WORD_OP
  - busy=0, fault=0, fault_code=00, counter=0
- **Reset mid-fetch:** reset overrides everything. RAM_enable drops in the same edge, and no IR_Enable follows.
- **Latency:** with fetch_req at edge N and MFC high on the first WAIT cycle, the edges are:
  - N: REQ entered
  - N+1: WAIT entered
  - N+2: LOAD entered, IR_Enable high for that cycle
  - N+3: back in IDLE
- **Minimum fetch:** 3 cycles of busy. Each extra MFC-low cycle adds one.
- **Output registration:** all outputs are registered or decoded from state only. There is no combinational path from MFC to IR_Enable.
- **Back-to-back:** fetch_req held high re-launches on the first IDLE cycle after LOAD, giving 4 cycles per instruction.

## Test plan
- **Normal fetch:**
  - Stimulus: PC=0x00000010, fetch_req pulse, MFC asserted 3 cycles after REQ with RAM_DataOut=0x82002003.
  - Required: RAM_Address=0x00000010 while busy; IR_In=0x82002003; IR_Enable and fetch_done high for exactly 1 cycle; busy low afterwards.
- **Misaligned PC:**
  - Stimulus: PC=0x00000006, fetch_req.
  - Required: fault=1 and fault_code=01 next cycle; RAM_enable never asserted.
  - Then fault_ack: IDLE, fault=0, fault_code=00.
- **Timeout:**
  - Stimulus: TIMEOUT=15, MFC held low.
  - Required: fault_code=10 after 15 WAIT cycles; RAM_enable=0 from then on; IR_In unchanged.
- **Flush vs MFC:**
  - Stimulus: flush and MFC high in the same WAIT cycle, RAM_DataOut=0xDEADBEEF.
  - Required: IDLE next cycle; no IR_Enable; IR_In keeps its prior value.
- **Reset mid-fetch:**
  - Stimulus: RESET during WAIT.
  - Required: next edge shows all outputs at their reset values; a subsequent fetch at PC=0x00000004 completes normally.
- **Back-to-back:**
  - Stimulus: fetch_req held high across PC=0x0, 0x4, 0x8 (data 0x84002006, 0x84004002, 0x05000000).
  - Required: three IR_Enable pulses 4 cycles apart, carrying the matching data.
